// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg
//   Shared types and constants for the push-button / slide-switch front end.
//   - btn_state_e : per-channel debounce FSM encoding
//   - BTN_*       : channel index of each DE2-115 key within btn_raw/btn_level
//   - *_DEF       : default block parameters (50 MHz clock, 10 ms debounce)
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int BTN_A  = 0;
  localparam int BTN_RD = 1;
  localparam int BTN_WR = 2;
  localparam int BTN_IT = 3;

  localparam int NUM_BTN_DEF         = 4;
  localparam int SW_W_DEF            = 16;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 19;

  // A channel is "busy" while it is still deciding whether a level change is real.
  function automatic logic is_wait(input btn_state_e s);
    return (s == PRESS_WAIT) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// debounce_channel
//   One push-button: 2-FF synchronizer, polarity fix, 4-state debounce FSM
//   with a saturating stability counter. All outputs are registered so the
//   downstream test unit sees glitch-free levels and a clean 1-clk pulse.
// Ports
//   clk    in   system clock
//   ar     in   asynchronous reset, active-high
//   raw    in   raw key input, asynchronous to clk
//   level  out  debounced pressed state (1 = pressed)
//   pulse  out  one-clk strobe on each accepted press
//   busy   out  channel is in PRESS_WAIT or RELEASE_WAIT
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic ar,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic busy
);

  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Sync flops reset to the not-pressed raw value so a reset never looks
  // like a press edge by itself.
  logic sync1, sync2, s;

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      sync1 <= POL;
      sync2 <= POL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ POL;

  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             done;
  logic             pulse_nxt, level_nxt, busy_nxt;

  // Saturating increment; the wait states decide on the value cnt is about
  // to take, so the transition lands exactly DEBOUNCE_CYCLES samples after
  // s first went to the new level.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign done    = (cnt_inc >= CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (done) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    busy_nxt  = is_wait(state_nxt);
  end

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
      level <= level_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Input stage for the DE2-115 memory test design. Each key gets its own
//   debounce channel (sync + FSM + counter); slide switches are only
//   synchronized, not debounced.
// Ports
//   clk        in   system clock
//   ar         in   asynchronous reset, active-high
//   btn_raw    in   [NUM_BTN] raw keys (A, Rd, Wr, IT), asynchronous
//   sw_raw     in   [SW_W]    raw slide switches, asynchronous
//   btn_level  out  [NUM_BTN] debounced pressed state, 1 = pressed
//   btn_pulse  out  [NUM_BTN] one-clk pulse per accepted press
//   sw_sync    out  [SW_W]    2-FF synchronized switches
//   busy       out  any channel still in a debounce wait state
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEF,
  parameter int SW_W            = SW_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               ar,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]    sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [SW_W-1:0]    sw_sync,
  output logic               busy
);

  logic [SW_W-1:0]    sw_meta;
  logic [NUM_BTN-1:0] ch_busy;

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_raw;
      sw_sync <= sw_meta;
    end
  end

  // Channels are fully independent; simultaneous pulses are left for the
  // consumer to prioritize.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .ar    (ar),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .pulse (btn_pulse[i]),
      .busy  (ch_busy[i])
    );
  end

  assign busy = |ch_busy;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic        clk = 1'b0;
  logic        ar;
  logic [3:0]  btn_raw;
  logic [15:0] sw_raw;
  logic [3:0]  btn_level, btn_pulse;
  logic [15:0] sw_sync;
  logic        busy;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .NUM_BTN(4), .SW_W(16), .DEBOUNCE_CYCLES(8), .CNT_W(4), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .ar(ar), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .sw_sync(sw_sync), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rep;
    logic        ar;
    logic [3:0]  btn;
    logic [15:0] sw;
    logic [3:0]  lvl;
    logic [3:0]  pls;
    logic [15:0] sync;
    logic        bsy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs read there
  // reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step n edges; report the first edge index (1-based) with any pulse,
  // the pulse vector seen there, and how many edges showed a pulse.
  task automatic watch(input int n, output int first, output logic [3:0] val, output int npulse);
    first = -1; val = '0; npulse = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (btn_pulse != 4'h0) begin
        npulse++;
        if (first < 0) begin
          first = k;
          val   = btn_pulse;
        end
      end
    end
  endtask

  int         first, npulse;
  logic [3:0] val;

  initial begin
    // rep, ar, btn, sw, exp level, exp pulse, exp sw_sync, exp busy
    // Clean press/release of Rd (bit 1) with switch traffic, then reset.
    tbl[0]  = '{1, 1'b0, 4'hD, 16'hA5C3, 4'h0, 4'h0, 16'h0000, 1'b0};
    tbl[1]  = '{1, 1'b0, 4'hD, 16'hA5C3, 4'h0, 4'h0, 16'hA5C3, 1'b0};
    tbl[2]  = '{2, 1'b0, 4'hD, 16'hA5C3, 4'h0, 4'h0, 16'hA5C3, 1'b1};
    tbl[3]  = '{1, 1'b0, 4'hD, 16'h5A3C, 4'h0, 4'h0, 16'hA5C3, 1'b1};
    tbl[4]  = '{4, 1'b0, 4'hD, 16'h5A3C, 4'h0, 4'h0, 16'h5A3C, 1'b1};
    tbl[5]  = '{1, 1'b0, 4'hD, 16'h5A3C, 4'h2, 4'h2, 16'h5A3C, 1'b0};
    tbl[6]  = '{2, 1'b0, 4'hD, 16'h5A3C, 4'h2, 4'h0, 16'h5A3C, 1'b0};
    tbl[7]  = '{2, 1'b0, 4'hF, 16'h5A3C, 4'h2, 4'h0, 16'h5A3C, 1'b0};
    tbl[8]  = '{7, 1'b0, 4'hF, 16'h5A3C, 4'h2, 4'h0, 16'h5A3C, 1'b1};
    tbl[9]  = '{1, 1'b0, 4'hF, 16'h5A3C, 4'h0, 4'h0, 16'h5A3C, 1'b0};
    tbl[10] = '{2, 1'b1, 4'hF, 16'h5A3C, 4'h0, 4'h0, 16'h0000, 1'b0};
    tbl[11] = '{1, 1'b0, 4'hF, 16'h5A3C, 4'h0, 4'h0, 16'h0000, 1'b0};
    tbl[12] = '{1, 1'b0, 4'hF, 16'h5A3C, 4'h0, 4'h0, 16'h5A3C, 1'b0};

    // Reset with every key held: outputs cleared, then one pulse on all.
    ar = 1'b1; btn_raw = 4'h0; sw_raw = 16'hFFFF;
    step(); step(); step();
    chk("rst.level", 32'(btn_level), 32'h0);
    chk("rst.pulse", 32'(btn_pulse), 32'h0);
    chk("rst.sw_sync", 32'(sw_sync), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    ar = 1'b0; sw_raw = 16'h0000;
    watch(20, first, val, npulse);
    chk("rst_held.pulse_edge", 32'(first), 32'd10);
    chk("rst_held.pulse_val", 32'(val), 32'hF);
    chk("rst_held.pulse_count", 32'(npulse), 32'd1);
    chk("rst_held.level", 32'(btn_level), 32'hF);
    btn_raw = 4'hF;
    repeat (12) step();
    chk("rst_held.released_level", 32'(btn_level), 32'h0);
    chk("rst_held.released_busy", 32'(busy), 32'h0);

    // Table-driven cycle-by-cycle vectors.
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].rep; k++) begin
        ar = tbl[r].ar; btn_raw = tbl[r].btn; sw_raw = tbl[r].sw;
        step();
        chk($sformatf("row%0d.%0d.level", r, k), 32'(btn_level), 32'(tbl[r].lvl));
        chk($sformatf("row%0d.%0d.pulse", r, k), 32'(btn_pulse), 32'(tbl[r].pls));
        chk($sformatf("row%0d.%0d.sw_sync", r, k), 32'(sw_sync), 32'(tbl[r].sync));
        chk($sformatf("row%0d.%0d.busy", r, k), 32'(busy), 32'(tbl[r].bsy));
      end
    end

    // Bounce on Wr: low 5, high 2, low 4, then high -- never accepted.
    ar = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      int n;
      n = (seg == 0) ? 5 : (seg == 1) ? 2 : (seg == 2) ? 4 : 15;
      btn_raw = 4'hF;
      btn_raw[BTN_WR] = seg[0];
      for (int k = 0; k < n; k++) begin
        step();
        chk($sformatf("bounce.s%0d.%0d", seg, k), 32'({btn_level[BTN_WR], btn_pulse[BTN_WR]}), 32'h0);
      end
    end
    chk("bounce.end_busy", 32'(busy), 32'h0);

    // Release bounce on A: glitch high 3 clks while held.
    btn_raw = 4'hF; btn_raw[BTN_A] = 1'b0;
    watch(14, first, val, npulse);
    chk("relb.press_edge", 32'(first), 32'd10);
    chk("relb.press_val", 32'(val), 32'h1);
    chk("relb.press_count", 32'(npulse), 32'd1);
    for (int k = 0; k < 15; k++) begin
      btn_raw[BTN_A] = (k < 3);
      step();
      chk($sformatf("relb.hold%0d", k), 32'({btn_level[BTN_A], btn_pulse}), 32'h10);
    end
    btn_raw = 4'hF;
    repeat (9) step();
    chk("relb.level_at_9", 32'(btn_level[BTN_A]), 32'h1);
    step();
    chk("relb.level_at_10", 32'(btn_level[BTN_A]), 32'h0);
    repeat (4) step();

    // Simultaneous A + IT.
    btn_raw = 4'hF; btn_raw[BTN_A] = 1'b0; btn_raw[BTN_IT] = 1'b0;
    watch(14, first, val, npulse);
    chk("simul.pulse_edge", 32'(first), 32'd10);
    chk("simul.pulse_val", 32'(val), 32'h9);
    chk("simul.pulse_count", 32'(npulse), 32'd1);
    btn_raw = 4'hF;
    repeat (14) step();

    // Reset in the middle of Rd's press debounce, key still held.
    btn_raw[BTN_RD] = 1'b0;
    repeat (5) step();
    chk("midrst.busy_before", 32'(busy), 32'h1);
    ar = 1'b1;
    step();
    chk("midrst.outputs", 32'({btn_level, btn_pulse, busy}), 32'h0);
    step();
    ar = 1'b0;
    watch(20, first, val, npulse);
    chk("midrst.pulse_edge", 32'(first), 32'd10);
    chk("midrst.pulse_val", 32'(val), 32'h2);
    chk("midrst.pulse_count", 32'(npulse), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
